mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan_pkg.sv | 44 ++++
 rtl/mux_scan_pick.sv | 31 +++
 rtl/mux_scan.sv | 133 +++++++++++++
 tb/tb_mux_scan.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module  : mux_scan_pkg
// Brief   : FSM state type and wrap-around next-masked-channel search.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

   localparam int c_max_ch = 64;
   localparam int c_idx_w  = 6;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   typedef struct packed {
      logic               found;
      logic [c_idx_w-1:0] idx;
   } pick_t;

   // First set mask bit strictly after ptr, wrapping at n_ch; ptr itself is
   // visited last so a lone masked channel is found again.
   function automatic pick_t next_masked(input logic [c_max_ch-1:0] mask,
                                         input logic [c_idx_w-1:0]  ptr,
                                         input int                  n_ch);
      pick_t r;
      int    k;
      r = '0;
      for (int i = 1; i <= c_max_ch; i++) begin
         k = int'(ptr) + i;
         if (k >= n_ch) k = k - n_ch;
         if (i <= n_ch && !r.found && k < c_max_ch && mask[k[c_idx_w-1:0]]) begin
            r.found = 1'b1;
            r.idx   = c_idx_w'(k);
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_pick.sv
// ============================================================================
// Module  : mux_scan_pick
// Brief   : Combinational finder of the next masked channel after a pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_pick
   import mux_scan_pkg::*;
#(
   parameter int N_CH  = 16,
   parameter int SEL_W = 4
)
(
   input  logic [N_CH-1:0]  mask,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             found
);

   pick_t w_pick;

   always_comb begin
      w_pick = next_masked(c_max_ch'(mask), c_idx_w'(ptr), N_CH);
      idx    = SEL_W'(w_pick.idx);
      found  = w_pick.found;
   end

endmodule

`default_nettype wire

// File: rtl/mux_scan.sv
// ============================================================================
// Module  : mux_scan
// Brief   : Registered N_CH:1 mux with direct-request and masked round-robin
//           scan modes. Optional macro MUX_SCAN_OOR_EN adds the err port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan
   import mux_scan_pkg::*;
#(
   parameter int  N_CH  = 16,
   parameter int  W     = 1,
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH*W-1:0] in,
   input  logic [SEL_W-1:0]  sel,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              scan_start,
   input  logic              scan_stop,
   input  logic [N_CH-1:0]   mask,
   output logic [W-1:0]      out,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready
`ifdef MUX_SCAN_OOR_EN
   ,
   output logic              err
`endif
);

   localparam logic [SEL_W-1:0] c_ptr_rst = SEL_W'(N_CH - 1);

   state_t           r_state, w_state_nxt;
   logic [SEL_W-1:0] r_ptr, r_out_ch;
   logic [W-1:0]     r_out, w_dsel, w_psel;
   logic             r_out_valid;
   logic             w_free, w_ld_dir, w_ld_scan, w_drop;
   logic [SEL_W-1:0] w_pick_idx;
   logic             w_pick_found;

   mux_scan_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
      .mask  (mask),
      .ptr   (r_ptr),
      .idx   (w_pick_idx),
      .found (w_pick_found)
   );

   assign w_free = !r_out_valid || out_ready;

   // Out-of-range sel matches no channel, so direct data falls back to zero.
   always_comb begin
      w_dsel = '0;
      w_psel = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (sel == SEL_W'(k))        w_dsel = in[k*W +: W];
         if (w_pick_idx == SEL_W'(k)) w_psel = in[k*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      w_ld_dir    = 1'b0;
      w_ld_scan   = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = w_free && !rst;
            w_ld_dir  = w_free && req_valid;
            w_drop    = w_free && !req_valid;
            if (scan_start && !scan_stop) w_state_nxt = SCAN;
         end
         SCAN: begin
            w_ld_scan = w_free && w_pick_found;
            w_drop    = w_free && !w_pick_found;
            if (scan_stop) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= c_ptr_rst;
         r_out       <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
      end else if (w_ld_dir) begin
         r_out       <= w_dsel;
         r_out_ch    <= sel;
         r_out_valid <= 1'b1;
      end else if (w_ld_scan) begin
         r_out       <= w_psel;
         r_out_ch    <= w_pick_idx;
         r_ptr       <= w_pick_idx;
         r_out_valid <= 1'b1;
      end else if (w_drop) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out       = r_out;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;

`ifdef MUX_SCAN_OOR_EN
   logic r_err;
   logic w_oor;

   assign w_oor = (int'(sel) >= N_CH);

   always_ff @(posedge clk) begin
      if (rst)                     r_err <= 1'b0;
      else if (w_ld_dir)           r_err <= w_oor;
      else if (w_ld_scan || w_drop) r_err <= 1'b0;
   end

   assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_scan.sv
// ============================================================================
// Module  : tb_mux_scan
// Brief   : Self-checking bench: 16-ch and 10-ch instances against a
//           behavioural model. Honours MUX_SCAN_OOR_EN for the err port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan;

   localparam int W     = 8;
   localparam int SEL_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [16*W-1:0]   in;
   logic [SEL_W-1:0]  sel;
   logic              req_valid, scan_start, scan_stop, out_ready;
   logic [15:0]       mask;
   logic              rr16, rr10, ov16, ov10;
   logic [W-1:0]      o16, o10;
   logic [SEL_W-1:0]  ch16, ch10;
`ifdef MUX_SCAN_OOR_EN
   logic              err16, err10;
`endif

   int checks   = 0;
   int failures = 0;
   int seq[5]   = '{0, 4, 15, 0, 4};

   // Model state per instance: index 0 is 16 channels, index 1 is 10.
   bit           m_scan[2]  = '{0, 0};
   int           m_ptr[2]   = '{15, 9};
   int           m_ch[2]    = '{0, 0};
   logic [W-1:0] m_out[2]   = '{8'h00, 8'h00};
   bit           m_valid[2] = '{0, 0};
   bit           m_err[2]   = '{0, 0};

   always #5 clk = ~clk;

   mux_scan #(.N_CH(16), .W(W)) dut16 (
      .clk(clk), .rst(rst), .in(in), .sel(sel), .req_valid(req_valid),
      .req_ready(rr16), .scan_start(scan_start), .scan_stop(scan_stop),
      .mask(mask), .out(o16), .out_ch(ch16), .out_valid(ov16),
      .out_ready(out_ready)
`ifdef MUX_SCAN_OOR_EN
      , .err(err16)
`endif
   );

   mux_scan #(.N_CH(10), .W(W)) dut10 (
      .clk(clk), .rst(rst), .in(in[10*W-1:0]), .sel(sel), .req_valid(req_valid),
      .req_ready(rr10), .scan_start(scan_start), .scan_stop(scan_stop),
      .mask(mask[9:0]), .out(o10), .out_ch(ch10), .out_valid(ov10),
      .out_ready(out_ready)
`ifdef MUX_SCAN_OOR_EN
      , .err(err10)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nch(input int d);
      return (d == 0) ? 16 : 10;
   endfunction

   function automatic bit exp_rr(input int d);
      return !rst && !m_scan[d] && (!m_valid[d] || out_ready);
   endfunction

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int n;
         int c;
         n = nch(d);
         if (rst) begin
            m_scan[d] = 0; m_ptr[d] = n - 1; m_out[d] = '0;
            m_ch[d] = 0; m_valid[d] = 0; m_err[d] = 0;
            continue;
         end
         if (!m_valid[d] || out_ready) begin
            m_valid[d] = 0;
            m_err[d]   = 0;
            if (!m_scan[d]) begin
               if (req_valid) begin
                  m_ch[d]    = int'(sel);
                  m_err[d]   = (int'(sel) >= n);
                  m_out[d]   = (int'(sel) < n) ? in[int'(sel)*W +: W] : '0;
                  m_valid[d] = 1;
               end
            end else begin
               for (int j = 1; j <= n; j++) begin
                  c = (m_ptr[d] + j) % n;
                  if (mask[c]) begin
                     m_out[d] = in[c*W +: W]; m_ch[d] = c; m_ptr[d] = c;
                     m_valid[d] = 1;
                     break;
                  end
               end
            end
         end
         if (scan_stop)       m_scan[d] = 0;
         else if (scan_start) m_scan[d] = 1;
      end
   endtask

   task automatic check_outs();
      chk("valid16", ov16, m_valid[0]);
      chk("out16",   o16,  m_out[0]);
      chk("ch16",    ch16, m_ch[0]);
      chk("valid10", ov10, m_valid[1]);
      chk("out10",   o10,  m_out[1]);
      chk("ch10",    ch10, m_ch[1]);
`ifdef MUX_SCAN_OOR_EN
      chk("err16", err16, m_err[0]);
      chk("err10", err10, m_err[1]);
`endif
   endtask

   // Called at a falling edge with inputs already applied; returns at the next one.
   task automatic tick();
      #1;
      chk("req_ready16", rr16, exp_rr(0));
      chk("req_ready10", rr10, exp_rr(1));
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outs();
   endtask

   initial begin
      rst = 1; in = '0; sel = '0; req_valid = 0; scan_start = 0; scan_stop = 0;
      mask = '0; out_ready = 1;
      @(negedge clk);
      tick();
      tick();
      chk("rst_valid", ov16, 0);
      chk("rst_out", o16, 0);
      chk("rst_ch", ch16, 0);
      rst = 0;

      in[5*W +: W] = 8'hA5; sel = 4'd5; req_valid = 1; out_ready = 1;
      tick();
      chk("dir_out", o16, 8'hA5);
      chk("dir_ch", ch16, 5);
      chk("dir_valid", ov16, 1);

      out_ready = 0; sel = 4'd3;
      for (int i = 0; i < 3; i++) begin
         in = {$urandom, $urandom, $urandom, $urandom};
         tick();
         chk("hold_out", o16, 8'hA5);
         chk("hold_ch", ch16, 5);
      end
      chk("hold_rr", rr16, 0);
      out_ready = 1; req_valid = 0;
      #1 chk("free_rr", rr16, 1);
      tick();
      chk("drain_valid", ov16, 0);

      mask = 16'h8011; scan_start = 1;
      tick();
      scan_start = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("scan_seq", ch16, seq[i]);
      end

      mask = 16'h0000;
      tick();
      chk("mask0_valid", ov16, 0);
      mask = 16'h0002;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("single_ch", ch16, 1);
         chk("single_valid", ov16, 1);
      end

      mask = 16'h00F0; out_ready = 0;
      tick();
      tick();
      rst = 1;
      tick();
      chk("rst_stall_valid", ov16, 0);
      rst = 0; out_ready = 1; scan_start = 1;
      tick();
      scan_start = 0;
      tick();
      chk("restart_ch16", ch16, 4);
      chk("restart_ch10", ch10, 4);

      scan_stop = 1;
      tick();
      scan_stop = 0; sel = 4'd12; req_valid = 1;
      tick();
      chk("oor_out", o10, 0);
      chk("oor_ch", ch10, 12);
`ifdef MUX_SCAN_OOR_EN
      chk("oor_err", err10, 1);
`endif
      req_valid = 0;

      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         in         = {$urandom, $urandom, $urandom, $urandom};
         sel        = 4'($urandom);
         req_valid  = ($urandom_range(0, 1) == 1);
         scan_start = ($urandom_range(0, 15) == 0);
         scan_stop  = ($urandom_range(0, 15) == 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = '0;
               1:       mask = 16'd1 << $urandom_range(0, 15);
               default: mask = 16'($urandom);
            endcase
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
